// File: rtl/pedal_pkg.sv
// Shared definitions for the audio receive path.
//
// Contents
//   I2S_MODE_I2S / I2S_MODE_LJ : values for the I2S_MODE parameter of i2s_rx_deser
//   rx_state_t                 : receive FSM state encoding
//   cnt_width()                : width of a counter that must hold 0..max_val
package pedal_pkg;

    localparam int I2S_MODE_I2S = 1;
    localparam int I2S_MODE_LJ  = 0;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        DELAY     = 2'd1,
        SHIFT     = 2'd2,
        PAD       = 2'd3
    } rx_state_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a bundle of asynchronous inputs.
// Every bit goes through the same number of stages, so bits that were
// aligned at the input stay aligned at the output.
//
// Parameters
//   WIDTH  : number of bits carried
//   STAGES : flop depth (2..4)
// Ports
//   bclk  in   sampling clock
//   reset in   synchronous active-high clear of every stage
//   d     in   WIDTH  asynchronous inputs
//   q     out  WIDTH  synchronised outputs (last stage)
module sync_ff #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             bclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge bclk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S / left-justified serial audio receiver. Deserialises one left and one
// right sample per frame and presents them together as a pair.
//
// Parameters
//   SAMPLE_W    : captured sample width (8..32)
//   SLOT_W      : maximum bit clocks per channel slot (>= SAMPLE_W+1)
//   I2S_MODE    : I2S_MODE_I2S = one-bit delay after LRCLK edge,
//                 I2S_MODE_LJ  = MSB on the LRCLK edge bit
//   SYNC_STAGES : synchroniser depth on lrclk/sdata (2..4)
// Ports
//   bclk      in   bit clock, only clock of the block
//   reset     in   synchronous active-high reset
//   lrclk     in   word select, 0 = left slot, 1 = right slot
//   sdata     in   serial data, MSB first
//   left_out  out  SAMPLE_W  last complete left sample
//   right_out out  SAMPLE_W  last complete right sample, paired with left_out
//   out_valid out  one-cycle pulse when a new pair is on the outputs
//   frame_err out  one-cycle pulse on a framing violation
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_EDGE | idle after reset or slot overrun; waiting for any LRCLK edge
// DELAY     | I2S only: discarding the bit that came with the LRCLK edge
// SHIFT     | shifting SAMPLE_W data bits in, MSB first
// PAD       | sample captured; ignoring the rest of the slot
module i2s_rx_deser
    import pedal_pkg::*;
#(
    parameter int SAMPLE_W    = 24,
    parameter int SLOT_W      = 32,
    parameter int I2S_MODE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                bclk,
    input  logic                reset,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                out_valid,
    output logic                frame_err
);

    localparam int CNT_W = cnt_width(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(SLOT_W - 1);
    // Slot bit index of the sample LSB: the I2S delay bit pushes it one later.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1 + I2S_MODE);

    logic [1:0] sync_q;
    logic       lr_s;
    logic       sd_s;
    logic       lr_d;
    logic       sd_d;
    logic       edge_det;

    rx_state_t           state;
    logic                channel;
    logic                have_left;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [SAMPLE_W-2:0] shreg;
    logic [SAMPLE_W-1:0] shift_next;
    logic [SAMPLE_W-1:0] left_hold;
    logic                sample_done;

    sync_ff #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .bclk  (bclk),
        .reset (reset),
        .d     ({lrclk, sdata}),
        .q     (sync_q)
    );

    assign lr_s = sync_q[1];
    assign sd_s = sync_q[0];

    // sd_d is the bit that travelled with lr_d. The edge is seen on lr_s one
    // cycle before the bit that came with it reaches sd_d, so the FSM has
    // already changed state when that bit is processed: DELAY drops it
    // (I2S), SHIFT takes it as MSB (left-justified).
    always_ff @(posedge bclk) begin
        if (reset) begin
            lr_d <= 1'b0;
            sd_d <= 1'b0;
        end else begin
            lr_d <= lr_s;
            sd_d <= sd_s;
        end
    end

    assign edge_det    = lr_s ^ lr_d;
    assign shift_next  = {shreg, sd_d};
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign sample_done = (state == SHIFT) && (cnt == LAST_BIT);

    always_ff @(posedge bclk) begin
        if (reset) begin
            state     <= WAIT_EDGE;
            channel   <= 1'b0;
            have_left <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            left_hold <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;

            // The final data bit may coincide with the next edge when the
            // slot is only SAMPLE_W+1 long; it still completes normally.
            if (sample_done) begin
                if (!channel) begin
                    left_hold <= shift_next;
                    have_left <= 1'b1;
                end else if (have_left) begin
                    left_out  <= left_hold;
                    right_out <= shift_next;
                    out_valid <= 1'b1;
                    have_left <= 1'b0;
                end
            end

            if (edge_det) begin
                channel <= lr_s;
                cnt     <= '0;
                shreg   <= '0;
                state   <= (I2S_MODE == I2S_MODE_I2S) ? DELAY : SHIFT;
                // A new left slot starts a new frame.
                if (!lr_s) begin
                    have_left <= 1'b0;
                end
                if ((state == SHIFT) && !sample_done) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    WAIT_EDGE: begin
                    end
                    DELAY: begin
                        cnt   <= cnt_inc;
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        cnt   <= cnt_inc;
                        shreg <= shift_next[SAMPLE_W-2:0];
                        if (sample_done) begin
                            state <= PAD;
                        end
                    end
                    PAD: begin
                        cnt <= cnt_inc;
                    end
                    default: begin
                        state <= WAIT_EDGE;
                    end
                endcase

                // Last bit clock of a full slot with no edge: overrun.
                if ((state != WAIT_EDGE) && (cnt == SLOT_END)) begin
                    frame_err <= 1'b1;
                    state     <= WAIT_EDGE;
                    cnt       <= '0;
                    have_left <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Scoreboard bench for i2s_rx_deser. Three instances (I2S 24-bit, LJ 24-bit,
// I2S 16-bit) share lrclk/sdata; only the instance under test is out of reset.
module tb_i2s_rx_deser;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    logic rst0, rst1, rst2;
    logic lrclk, sdata;
    logic [23:0] l0, r0, l1, r1;
    logic [15:0] l2, r2;
    logic v0, v1, v2, e0, e1, e2;

    i2s_rx_deser #(.SAMPLE_W(24), .SLOT_W(32), .I2S_MODE(1), .SYNC_STAGES(2)) dut_i2s (
        .bclk(bclk), .reset(rst0), .lrclk(lrclk), .sdata(sdata),
        .left_out(l0), .right_out(r0), .out_valid(v0), .frame_err(e0));

    i2s_rx_deser #(.SAMPLE_W(24), .SLOT_W(32), .I2S_MODE(0), .SYNC_STAGES(2)) dut_lj (
        .bclk(bclk), .reset(rst1), .lrclk(lrclk), .sdata(sdata),
        .left_out(l1), .right_out(r1), .out_valid(v1), .frame_err(e1));

    i2s_rx_deser #(.SAMPLE_W(16), .SLOT_W(32), .I2S_MODE(1), .SYNC_STAGES(2)) dut_16 (
        .bclk(bclk), .reset(rst2), .lrclk(lrclk), .sdata(sdata),
        .left_out(l2), .right_out(r2), .out_valid(v2), .frame_err(e2));

    typedef struct {
        int          dut;
        logic [23:0] l;
        logic [23:0] r;
        int          lat;   // cycles after right-edge drive; 0 = not checked
    } exp_t;

    exp_t        pair_q[$];
    exp_t        err_q[$];
    int          n_checks;
    int          n_errors;
    int          cyc = 0;
    int          r_edge_cyc;
    logic [23:0] last_l, last_r;

    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [23:0] lo[3];
        logic [23:0] ro[3];
        logic        vl[3];
        logic        er[3];
        exp_t        e;
        forever begin
            @(negedge bclk);
            lo = '{l0, l1, {8'h00, l2}};
            ro = '{r0, r1, {8'h00, r2}};
            vl = '{v0, v1, v2};
            er = '{e0, e1, e2};
            for (int d = 0; d < 3; d++) begin
                if (vl[d]) begin
                    check($sformatf("dut%0d_valid_expected", d), 32'(pair_q.size() != 0), 1);
                    if (pair_q.size() != 0) begin
                        e = pair_q.pop_front();
                        check("valid_dut_id", d, e.dut);
                        check($sformatf("dut%0d_left_out", d), lo[d], e.l);
                        check($sformatf("dut%0d_right_out", d), ro[d], e.r);
                        if (e.lat != 0) check($sformatf("dut%0d_valid_latency", d), cyc - r_edge_cyc, e.lat);
                    end
                end
                if (er[d]) begin
                    check($sformatf("dut%0d_frame_err_expected", d), 32'(err_q.size() != 0), 1);
                    if (err_q.size() != 0) begin
                        e = err_q.pop_front();
                        check("err_dut_id", d, e.dut);
                        check($sformatf("dut%0d_left_hold_at_err", d), lo[d], e.l);
                        check($sformatf("dut%0d_right_hold_at_err", d), ro[d], e.r);
                        if (e.lat != 0) check($sformatf("dut%0d_err_latency", d), cyc - r_edge_cyc, e.lat);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic lr, input logic sd);
        @(negedge bclk);
        lrclk = lr;
        sdata = sd;
    endtask

    // One slot: delay bits of pad, width data bits MSB first, then pad.
    task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits,
                             input int width, input int delay, input logic pad);
        int   idx;
        logic b;
        for (int k = 0; k < nbits; k++) begin
            idx = k - delay;
            b   = (idx >= 0 && idx < width) ? data[width-1-idx] : pad;
            drive(lr, b);
            if (k == 0 && lr) r_edge_cyc = cyc;
        end
    endtask

    task automatic send_frame(input int dut, input logic [23:0] l, input logic [23:0] r,
                              input int width, input int delay, input logic pad,
                              input bit expect_pair, input int lat,
                              input int err_lat, input int rbits);
        exp_t e;
        send_slot(1'b0, 32'(l), 32, width, delay, pad);
        if (expect_pair) begin
            e = '{dut: dut, l: l, r: r, lat: lat};
            pair_q.push_back(e);
            last_l = l;
            last_r = r;
        end
        if (err_lat >= 0) begin
            e = '{dut: dut, l: last_l, r: last_r, lat: err_lat};
            err_q.push_back(e);
        end
        send_slot(1'b1, 32'(r), rbits, width, delay, pad);
    endtask

    task automatic idle(input int n, input logic sd);
        for (int k = 0; k < n; k++) drive(1'b0, sd);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((pair_q.size() != 0 || err_q.size() != 0) && n < 200) begin
            @(negedge bclk);
            n++;
        end
        check("pairs_drained", pair_q.size(), 0);
        check("errs_drained", err_q.size(), 0);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        lrclk = 1'b0; sdata = 1'b0;
        n_checks = 0; n_errors = 0;
        last_l = '0; last_r = '0; r_edge_cyc = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge bclk);
        check("rst_dut0_left", l0, 0);  check("rst_dut0_right", r0, 0);
        check("rst_dut0_valid", v0, 0); check("rst_dut0_err", e0, 0);
        check("rst_dut1_left", l1, 0);  check("rst_dut1_right", r1, 0);
        check("rst_dut1_valid", v1, 0); check("rst_dut1_err", e1, 0);
        check("rst_dut2_left", l2, 0);  check("rst_dut2_right", r2, 0);
        check("rst_dut2_valid", v2, 0); check("rst_dut2_err", e2, 0);

        // ---------------- I2S, 24-bit ----------------
        rst0 = 1'b0;
        idle(4, 1'b0);
        send_slot(1'b1, 32'h0055AA, 32, 24, 1, 1'b0);   // orphan right: no pair
        send_frame(0, 24'hABCDEF, 24'h123456, 24, 1, 1'b0, 1, 28, -1, 32);
        send_frame(0, 24'h5A0F3C, 24'h800001, 24, 1, 1'b1, 1, 28, -1, 32);
        // right slot cut to 10 bits: error, outputs hold the previous pair
        send_frame(0, 24'h777777, 24'h654321, 24, 1, 1'b0, 0, 0, 0, 10);
        send_frame(0, 24'hC0FFEE, 24'h0BADF0, 24, 1, 1'b0, 1, 28, -1, 32);
        // right slot held 40 bclk: pair completes, then overrun at bit 32
        send_frame(0, 24'h13579B, 24'h2468AC, 24, 1, 1'b0, 1, 28, 35, 40);
        send_frame(0, 24'hFEDCBA, 24'h012345, 24, 1, 1'b1, 1, 28, -1, 32);
        wait_drain();
        // reset at bit 12 of a left slot
        for (int k = 0; k < 12; k++) drive(1'b0, 1'(k % 2));
        rst0 = 1'b1; lrclk = 1'b0; sdata = 1'b0;
        repeat (2) @(negedge bclk);
        check("midrst_left", l0, 0);  check("midrst_right", r0, 0);
        check("midrst_valid", v0, 0); check("midrst_err", e0, 0);
        rst0 = 1'b0;
        idle(4, 1'b0);
        send_slot(1'b1, 32'h000000, 32, 24, 1, 1'b0);
        send_frame(0, 24'h00FF00, 24'hFF00FF, 24, 1, 1'b0, 1, 28, -1, 32);
        wait_drain();
        idle(6, 1'b0);
        rst0 = 1'b1;

        // ---------------- left-justified, 24-bit ----------------
        rst1 = 1'b0;
        idle(4, 1'b0);
        send_slot(1'b1, 32'h0055AA, 32, 24, 0, 1'b0);
        send_frame(1, 24'hABCDEF, 24'h123456, 24, 0, 1'b0, 1, 27, -1, 32);
        wait_drain();
        idle(6, 1'b0);
        rst1 = 1'b1;

        // ---------------- I2S, 16-bit, pad bits all ones ----------------
        rst2 = 1'b0;
        idle(4, 1'b1);
        send_slot(1'b1, 32'h0000FFFF, 32, 16, 1, 1'b1);
        send_frame(2, 24'h00FFFF, 24'h00FFFF, 16, 1, 1'b1, 1, 0, -1, 32);
        send_frame(2, 24'h00FFFF, 24'h00FFFF, 16, 1, 1'b1, 1, 0, -1, 32);
        send_frame(2, 24'h00A5C3, 24'h005A3C, 16, 1, 1'b1, 1, 0, -1, 32);
        wait_drain();
        idle(6, 1'b1);
        rst2 = 1'b1;

        repeat (4) @(negedge bclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
